cla_sub_pipe: RTL and testbench

CLA_SUB_PIPE -- requirements
Module: cla_sub_pipe

---
 rtl/cla_sub_pipe.sv | 144 ++++++++++++++
 tb/tb_cla_sub_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: 16-bit subtractor built from four 4-bit carry-look-ahead
// slices, one slice per pipeline stage. Each stage computes one nibble
// of a + ~b + ~bin and hands its carry to the next stage. The operand
// bits still needed by later stages travel with their transaction.
// A single global stall freezes every stage while the output is
// valid but not accepted.
module cla_sub_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        zero,
  output logic        out_valid,
  input  logic        out_ready
);

  // 4-bit carry-look-ahead slice; returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c_in);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    p    = x ^ y;
    g    = x & y;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Stage 0: low nibble done, upper operand bits skewed forward.
  logic        v0_q;
  logic        c0_q;
  logic [3:0]  d0_q;
  logic [15:4] a0_q;
  logic [15:4] nb0_q;
  // Stage 1
  logic        v1_q;
  logic        c1_q;
  logic [7:0]  d1_q;
  logic [15:8] a1_q;
  logic [15:8] nb1_q;
  // Stage 2
  logic        v2_q;
  logic        c2_q;
  logic [11:0] d2_q;
  logic [15:12] a2_q;
  logic [15:12] nb2_q;
  // Stage 3: output registers
  logic        out_valid_q;
  logic [15:0] diff_q;
  logic        bout_q;
  logic        ovf_q;
  logic        zero_q;

  logic        stall_s;
  logic [4:0]  sum0_d;
  logic [4:0]  sum1_d;
  logic [4:0]  sum2_d;
  logic [4:0]  sum3_d;
  logic [15:0] diff_d;
  logic        bout_d;
  logic        ovf_d;
  logic        zero_d;

  assign stall_s  = out_valid_q & ~out_ready;
  assign in_ready = ~stall_s;

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Per-stage slice arithmetic and the final flag derivation.
  always_comb begin
    sum0_d = cla4(a[3:0], ~b[3:0], ~bin);
    sum1_d = cla4(a0_q[7:4], nb0_q[7:4], c0_q);
    sum2_d = cla4(a1_q[11:8], nb1_q[11:8], c1_q);
    sum3_d = cla4(a2_q[15:12], nb2_q[15:12], c2_q);
    diff_d = {sum3_d[3:0], d2_q};
    bout_d = ~sum3_d[4];
    // nb2_q holds ~b, so b[15] of this transaction is ~nb2_q[15].
    ovf_d  = (a2_q[15] != ~nb2_q[15]) && (diff_d[15] != a2_q[15]);
    zero_d = (diff_d == 16'h0000);
  end

  // Pipeline advance: all stages move together unless the output stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q        <= 1'b0;
      c0_q        <= 1'b0;
      d0_q        <= 4'h0;
      a0_q        <= 12'h000;
      nb0_q       <= 12'h000;
      v1_q        <= 1'b0;
      c1_q        <= 1'b0;
      d1_q        <= 8'h00;
      a1_q        <= 8'h00;
      nb1_q       <= 8'h00;
      v2_q        <= 1'b0;
      c2_q        <= 1'b0;
      d2_q        <= 12'h000;
      a2_q        <= 4'h0;
      nb2_q       <= 4'h0;
      out_valid_q <= 1'b0;
      diff_q      <= 16'h0000;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (!stall_s) begin
      v0_q        <= in_valid;
      c0_q        <= sum0_d[4];
      d0_q        <= sum0_d[3:0];
      a0_q        <= a[15:4];
      nb0_q       <= ~b[15:4];
      v1_q        <= v0_q;
      c1_q        <= sum1_d[4];
      d1_q        <= {sum1_d[3:0], d0_q};
      a1_q        <= a0_q[15:8];
      nb1_q       <= nb0_q[15:8];
      v2_q        <= v1_q;
      c2_q        <= sum2_d[4];
      d2_q        <= {sum2_d[3:0], d1_q};
      a2_q        <= a1_q[15:12];
      nb2_q       <= nb1_q[15:12];
      out_valid_q <= v2_q;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Self-checking bench for cla_sub_pipe: directed vectors with hand-computed
// results, a stall during streaming, a mid-flight reset pulse, and a random
// phase against an arithmetic reference.
module tb_cla_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;
  logic        out_valid;
  logic        out_ready;

  int          n_chk = 0;
  int          n_err = 0;
  logic [18:0] exp_q[$];   // {ovf, zero, bout, diff}
  logic [18:0] mon_e;
  logic [31:0] outs_s;
  logic        acc;

  cla_sub_pipe dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .bin(bin), .in_valid(in_valid),
    .in_ready(in_ready), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  assign outs_s = {13'd0, ovf, zero, bout, diff};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    logic [16:0] r;
    r = {1'b0, x} - {1'b0, y} - {16'd0, c};
    return {(x[15] != y[15]) && (r[15] != x[15]), r[15:0] == 16'h0000, r[16], r[15:0]};
  endfunction

  // Output monitor: every accepted result is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", outs_s, {13'd0, mon_e});
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c,
                      input logic [18:0] e);
    int k;
    a = x; b = y; bin = c; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    exp_q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  logic [15:0] va [8] = '{16'h0010, 16'h00FF, 16'h7FFF, 16'hFFFF,
                          16'h1000, 16'hABCD, 16'h1234, 16'h8000};
  logic [15:0] vb [8] = '{16'h0001, 16'h00FF, 16'hFFFF, 16'h0001,
                          16'h0FFF, 16'h1234, 16'hABCD, 16'h7FFF};
  logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  // {ovf, zero, bout, diff}
  logic [18:0] ve [8] = '{{3'b000, 16'h000F}, {3'b001, 16'hFFFF},
                          {3'b101, 16'h8000}, {3'b000, 16'hFFFE},
                          {3'b010, 16'h0000}, {3'b000, 16'h9999},
                          {3'b001, 16'h6667}, {3'b110, 16'h0000}};

  initial begin
    int idx;
    int cyc;
    rst_n = 1'b0; a = 16'h0000; b = 16'h0000; bin = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outs", outs_s, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic subtraction and exact latency.
    send(16'h0005, 16'h0003, 1'b0, {3'b000, 16'h0002});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("latency", {31'd0, out_valid}, (i == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;

    // Borrow, signed overflow, zero, borrow-in boundaries.
    send(16'h0000, 16'h0001, 1'b0, {3'b001, 16'hFFFF});
    send(16'h8000, 16'h0001, 1'b0, {3'b100, 16'h7FFF});
    send(16'h1234, 16'h1234, 1'b0, {3'b010, 16'h0000});
    send(16'h1234, 16'h1234, 1'b1, {3'b001, 16'hFFFF});
    drain();

    // Back-to-back stream with a three-cycle output stall mid-stream.
    idx = 0; cyc = 0;
    while (idx < 8 && cyc < 40) begin
      a = va[idx]; b = vb[idx]; bin = vc[idx]; in_valid = 1'b1;
      out_ready = !(cyc >= 5 && cyc <= 7);
      @(negedge clk);
      chk("stream_in_ready", {31'd0, in_ready}, (cyc >= 5 && cyc <= 7) ? 32'd0 : 32'd1);
      if (cyc >= 5 && cyc <= 7 && exp_q.size() != 0)
        chk("stall_hold", outs_s, {13'd0, exp_q[0]});
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(ve[idx]);
        idx++;
      end
      #1 cyc++;
    end
    chk("stream_count", 32'(idx), 32'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Mid-flight reset pulse shorter than a clock cycle.
    out_ready = 1'b0;
    send(16'h4444, 16'h1111, 1'b0, {3'b000, 16'h3333});
    send(16'h0001, 16'h0002, 1'b0, {3'b001, 16'hFFFF});
    send(16'h2222, 16'h2222, 1'b0, {3'b010, 16'h0000});
    @(posedge clk); #2;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_pulse_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pulse_outs", outs_s, 32'd0);
    chk("rst_pulse_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(16'h0100, 16'h0001, 1'b1, {3'b000, 16'h00FE});
    drain();

    // Random traffic with random bubbles and back-pressure.
    for (int n = 0; n < 20000; n++) begin
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) exp_q.push_back(model(a, b, bin));
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
